// File: rtl/gf_mix_column_pipe.sv
// Purpose: pipelined AES MixColumns / InvMixColumns / bypass over NUM_COLS 32-bit columns per beat.
// Latency: PIPE_STAGES cycles from acceptance to OutValid; one beat per cycle sustained.
// Backpressure: global stall; InReady = OutReady | ~OutValid, and every stage holds while stalled.
//
// Ports:
//   Clk, Rst           clock (rising edge) and asynchronous active-high reset
//   InValid/InReady    input handshake; InMode (00 fwd, 01 inv, 1x bypass) and InData sampled on accept
//   OutValid/OutReady  output handshake; OutData/OutMode held stable while stalled
//   InData/OutData     column 0 in the MSBs, byte 0 of each column in its MSBs
module gf_mix_column_pipe #(
   parameter int NUM_COLS    = 4,
   parameter int PIPE_STAGES = 2
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic [1:0]             InMode,
   input  logic [32*NUM_COLS-1:0] InData,
   output logic                   OutValid,
   input  logic                   OutReady,
   output logic [32*NUM_COLS-1:0] OutData,
   output logic [1:0]             OutMode
);

   localparam int W = 32 * NUM_COLS;

   // One shared advance for the whole pipe: bubbles shift like real beats,
   // so ordering and latency stay fixed.
   logic adv;
   assign adv     = OutReady | ~OutValid;
   assign InReady = adv;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte-wise xtime across the whole beat; byte position does not matter here.
   function automatic logic [W-1:0] xtime_vec(input logic [W-1:0] d);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W / 8; i++) begin
         r[8*i +: 8] = xtime(d[8*i +: 8]);
      end
      return r;
   endfunction

   // Byte j (mod 4) of a column word, byte 0 being the MSB.
   function automatic logic [7:0] bsel(input logic [31:0] w, input int j);
      return w[31-8*(j%4) -: 8];
   endfunction

   // XOR combination of precomputed multiples for one column.
   //   3 = 2^1, E = 8^4^2, B = 8^2^1, D = 8^4^1, 9 = 8^1
   function automatic logic [31:0] mix_col(input logic [31:0] a,
                                           input logic [31:0] m2,
                                           input logic [31:0] m4,
                                           input logic [31:0] m8,
                                           input logic [1:0]  mode);
      logic [31:0] r;
      r = a;
      for (int i = 0; i < 4; i++) begin
         case (mode)
            2'b00: r[31-8*i -: 8] = bsel(m2, i)
                                  ^ bsel(m2, i+1) ^ bsel(a, i+1)
                                  ^ bsel(a, i+2)
                                  ^ bsel(a, i+3);
            2'b01: r[31-8*i -: 8] = (bsel(m8, i)   ^ bsel(m4, i)   ^ bsel(m2, i))
                                  ^ (bsel(m8, i+1) ^ bsel(m2, i+1) ^ bsel(a, i+1))
                                  ^ (bsel(m8, i+2) ^ bsel(m4, i+2) ^ bsel(a, i+2))
                                  ^ (bsel(m8, i+3) ^ bsel(a, i+3));
            default: r[31-8*i -: 8] = bsel(a, i);
         endcase
      end
      return r;
   endfunction

   function automatic logic [W-1:0] mix_vec(input logic [W-1:0] a,
                                            input logic [W-1:0] m2,
                                            input logic [W-1:0] m4,
                                            input logic [W-1:0] m8,
                                            input logic [1:0]   mode);
      logic [W-1:0] r;
      r = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         r[W-1-32*c -: 32] = mix_col(a[W-1-32*c -: 32], m2[W-1-32*c -: 32],
                                     m4[W-1-32*c -: 32], m8[W-1-32*c -: 32], mode);
      end
      return r;
   endfunction

   // Multiples of the incoming beat, feeding either the only stage or stage 1.
   logic [W-1:0] in_x2, in_x4, in_x8;
   assign in_x2 = xtime_vec(InData);
   assign in_x4 = xtime_vec(in_x2);
   assign in_x8 = xtime_vec(in_x4);

   generate
      if (PIPE_STAGES == 1) begin : g_one
         // Multiply and combine in a single stage.
         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
               OutValid <= 1'b0;
               OutMode  <= 2'b00;
               OutData  <= '0;
            end else if (adv) begin
               OutValid <= InValid;
               OutMode  <= InMode;
               OutData  <= mix_vec(InData, in_x2, in_x4, in_x8, InMode);
            end
         end
      end else begin : g_multi
         logic         s1_vld;
         logic [1:0]   s1_mode;
         logic [W-1:0] s1_raw, s1_x2, s1_x4, s1_x8;
         logic [W-1:0] s1_mix;

         // Stage 1: raw bytes plus their x2/x4/x8 multiples.
         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
               s1_vld  <= 1'b0;
               s1_mode <= 2'b00;
               s1_raw  <= '0;
               s1_x2   <= '0;
               s1_x4   <= '0;
               s1_x8   <= '0;
            end else if (adv) begin
               s1_vld  <= InValid;
               s1_mode <= InMode;
               s1_raw  <= InData;
               s1_x2   <= in_x2;
               s1_x4   <= in_x4;
               s1_x8   <= in_x8;
            end
         end

         assign s1_mix = mix_vec(s1_raw, s1_x2, s1_x4, s1_x8, s1_mode);

         if (PIPE_STAGES == 2) begin : g_two
            always_ff @(posedge Clk or posedge Rst) begin
               if (Rst) begin
                  OutValid <= 1'b0;
                  OutMode  <= 2'b00;
                  OutData  <= '0;
               end else if (adv) begin
                  OutValid <= s1_vld;
                  OutMode  <= s1_mode;
                  OutData  <= s1_mix;
               end
            end
         end else begin : g_three
            logic         s2_vld;
            logic [1:0]   s2_mode;
            logic [W-1:0] s2_dat;

            // Stage 2 holds the XOR result; the output stage is a plain retiming register.
            always_ff @(posedge Clk or posedge Rst) begin
               if (Rst) begin
                  s2_vld   <= 1'b0;
                  s2_mode  <= 2'b00;
                  s2_dat   <= '0;
                  OutValid <= 1'b0;
                  OutMode  <= 2'b00;
                  OutData  <= '0;
               end else if (adv) begin
                  s2_vld   <= s1_vld;
                  s2_mode  <= s1_mode;
                  s2_dat   <= s1_mix;
                  OutValid <= s2_vld;
                  OutMode  <= s2_mode;
                  OutData  <= s2_dat;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_gf_mix_column_pipe.sv
// Purpose: self-checking bench for gf_mix_column_pipe (4 cols / 2 stages, plus 1 col at 1 and 3 stages).
// Latency: checks exact acceptance-to-OutValid latency per configuration.
// Backpressure: exercises a 5-cycle OutReady drop, random stalls and reset with beats in flight.
module tb_gf_mix_column_pipe;

   logic         clk;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [1:0]   in_mode, out_mode;
   logic [127:0] in_data, out_data;

   logic         sw_valid, sw_out_ready;
   logic [1:0]   sw_mode;
   logic [31:0]  sw_data;
   logic         p1_in_ready, p1_out_valid, p3_in_ready, p3_out_valid;
   logic [1:0]   p1_out_mode, p3_out_mode;
   logic [31:0]  p1_out_data, p3_out_data;

   gf_mix_column_pipe #(.NUM_COLS(4), .PIPE_STAGES(2)) u_dut (
      .Clk(clk), .Rst(rst),
      .InValid(in_valid), .InReady(in_ready), .InMode(in_mode), .InData(in_data),
      .OutValid(out_valid), .OutReady(out_ready), .OutData(out_data), .OutMode(out_mode));

   gf_mix_column_pipe #(.NUM_COLS(1), .PIPE_STAGES(1)) u_p1 (
      .Clk(clk), .Rst(rst),
      .InValid(sw_valid), .InReady(p1_in_ready), .InMode(sw_mode), .InData(sw_data),
      .OutValid(p1_out_valid), .OutReady(sw_out_ready), .OutData(p1_out_data), .OutMode(p1_out_mode));

   gf_mix_column_pipe #(.NUM_COLS(1), .PIPE_STAGES(3)) u_p3 (
      .Clk(clk), .Rst(rst),
      .InValid(sw_valid), .InReady(p3_in_ready), .InMode(sw_mode), .InData(sw_data),
      .OutValid(p3_out_valid), .OutReady(sw_out_ready), .OutData(p3_out_data), .OutMode(p3_out_mode));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;
   int pushes   = 0;
   int pops     = 0;

   typedef struct {
      logic [1:0]   mode;
      logic [127:0] dat;
   } beat_t;
   beat_t exp_q[$];
   beat_t mon_b;

   typedef struct {
      logic [1:0]   mode;
      logic [127:0] dat;
      logic [127:0] exp;
   } vec_t;
   vec_t tbl[7];

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] dat;
      logic [31:0] exp;
   } svec_t;
   svec_t sv[8];

   // GF(2^8) multiply by shift-and-add, reduced by x^8+x^4+x^3+x+1.
   function automatic int gf_mul(input int x, input int y);
      int p = 0;
      for (int i = 0; i < 8; i++) begin
         if (((y >> i) & 1) != 0) p ^= x;
         x = x << 1;
         if ((x & 'h100) != 0) x ^= 'h11b;
      end
      return p & 'hff;
   endfunction

   // Matrix-times-column reference; ncols columns packed at the bottom of d.
   function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic [1:0] mode, input int ncols);
      logic [127:0] r;
      int a[4];
      int coef[4];
      int acc;
      r = '0;
      for (int c = 0; c < ncols; c++) begin
         for (int i = 0; i < 4; i++) a[i] = int'(d[32*(ncols-c)-1-8*i -: 8]);
         if (mode == 2'b00) coef = '{2, 3, 1, 1};
         else               coef = '{14, 11, 13, 9};
         for (int i = 0; i < 4; i++) begin
            if (mode[1]) acc = a[i];
            else begin
               acc = 0;
               for (int k = 0; k < 4; k++) acc ^= gf_mul(coef[k], a[(i+k)%4]);
            end
            r[32*(ncols-c)-1-8*i -: 8] = 8'(acc);
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard for the 4-column instance: every accepted beat must come out once, in order.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got data %h with no beat pending, required none", out_data);
            end else begin
               mon_b = exp_q.pop_front();
               chk("stream_data", out_data, mon_b.dat);
               chk("stream_mode", {126'b0, out_mode}, {126'b0, mon_b.mode});
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back('{mode: in_mode, dat: ref_mix(in_data, in_mode, 4)});
            pushes++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0]  vhist;
      logic [1:0]   bp_mode[10];
      logic [127:0] bp_dat[10];
      logic [127:0] tmp;
      logic         acc;
      int           idx, cyc, lat1, lat3;
      logic [31:0]  d1, d3;

      rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_data = '0; out_ready = 1'b1;
      sw_valid = 1'b0; sw_mode = 2'b00; sw_data = '0; sw_out_ready = 1'b1;

      tbl[0] = '{2'b00, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
      tbl[1] = '{2'b01, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
      tbl[2] = '{2'b00, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
      tbl[3] = '{2'b01, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
      tbl[4] = '{2'b10, 128'h01234567_89abcdef_fedcba98_76543210, 128'h01234567_89abcdef_fedcba98_76543210};
      tbl[5] = '{2'b11, 128'h01234567_89abcdef_fedcba98_76543210, 128'h01234567_89abcdef_fedcba98_76543210};
      tbl[6] = '{2'b00, 128'h0, 128'h0};

      // Reset state
      step();
      step();
      chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_out_mode", {126'b0, out_mode}, 128'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {127'b0, in_ready}, 128'd1);

      // Known-answer vectors, single beats, exact 2-cycle latency
      for (int t = 0; t < 7; t++) begin
         in_valid = 1'b1; in_mode = tbl[t].mode; in_data = tbl[t].dat;
         step();
         in_valid = 1'b0; in_data = 'x;
         chk($sformatf("tbl%0d_not_yet_valid", t), {127'b0, out_valid}, 128'd0);
         step();
         chk($sformatf("tbl%0d_valid", t), {127'b0, out_valid}, 128'd1);
         chk($sformatf("tbl%0d_data", t), out_data, tbl[t].exp);
         chk($sformatf("tbl%0d_mode", t), {126'b0, out_mode}, {126'b0, tbl[t].mode});
         step();
      end

      // Back-to-back stream of 8 beats with mixed modes: outputs on 8 consecutive cycles
      vhist = '0;
      for (int c = 0; c < 12; c++) begin
         vhist[c] = out_valid;
         if (c < 8) begin
            in_valid = 1'b1; in_mode = 2'(c % 3);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
         end else in_valid = 1'b0;
         step();
      end
      chk("b2b_valid_pattern", {116'b0, vhist}, 128'h3fc);

      // Backpressure: OutReady low for 5 cycles mid-stream
      for (int k = 0; k < 10; k++) begin
         bp_mode[k] = 2'($urandom_range(0, 3));
         bp_dat[k]  = {$urandom, $urandom, $urandom, $urandom};
      end
      idx = 0;
      cyc = 0;
      while ((idx < 10 || exp_q.size() != 0) && cyc < 60) begin
         out_ready = !(cyc >= 6 && cyc < 11);
         if (idx < 10) begin
            in_valid = 1'b1; in_mode = bp_mode[idx]; in_data = bp_dat[idx];
         end else in_valid = 1'b0;
         #1;
         if (!out_ready) begin
            chk("bp_in_ready_low", {127'b0, in_ready}, 128'd0);
            chk("bp_out_valid_held", {127'b0, out_valid}, 128'd1);
            if (exp_q.size() != 0) begin
               chk("bp_hold_data", out_data, exp_q[0].dat);
               chk("bp_hold_mode", {126'b0, out_mode}, {126'b0, exp_q[0].mode});
            end
         end
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
         cyc++;
      end
      out_ready = 1'b1; in_valid = 1'b0;
      chk("bp_all_accepted", 128'(idx), 128'd10);
      chk("bp_all_retired", 128'(exp_q.size()), 128'd0);

      // Random traffic with random stalls
      for (int c = 0; c < 150; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_mode   = 2'($urandom_range(0, 3));
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) step();
      chk("rand_drained", 128'(exp_q.size()), 128'd0);
      chk("rand_pops_eq_pushes", 128'(pops), 128'(pushes));

      // Reset with two beats in flight
      in_valid = 1'b1; in_mode = 2'b00; in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      in_mode = 2'b01; in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      exp_q.delete();
      pushes = 0;
      pops   = 0;
      #1;
      chk("rst_async_valid", {127'b0, out_valid}, 128'd0);
      chk("rst_async_data", out_data, 128'd0);
      chk("rst_async_mode", {126'b0, out_mode}, 128'd0);
      step();
      step();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("post_rst_idle%0d", c), {127'b0, out_valid}, 128'd0);
         step();
      end
      chk("post_rst_in_ready", {127'b0, in_ready}, 128'd1);
      in_valid = 1'b1; in_mode = 2'b01; in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      in_valid = 1'b0;
      step();
      chk("post_rst_new_valid", {127'b0, out_valid}, 128'd1);
      step();
      step();
      chk("post_rst_pops", 128'(pops), 128'd1);
      chk("post_rst_pushes", 128'(pushes), 128'd1);

      // Single-column instances at 1 and 3 stages
      sv[0] = '{2'b00, 32'hdb135345, 32'h8e4da1bc};
      sv[1] = '{2'b01, 32'h8e4da1bc, 32'hdb135345};
      for (int k = 2; k < 8; k++) begin
         sv[k].mode = 2'($urandom_range(0, 3));
         sv[k].dat  = $urandom;
         tmp        = ref_mix({96'b0, sv[k].dat}, sv[k].mode, 1);
         sv[k].exp  = tmp[31:0];
      end
      for (int k = 0; k < 8; k++) begin
         sw_valid = 1'b1; sw_mode = sv[k].mode; sw_data = sv[k].dat;
         step();
         sw_valid = 1'b0;
         lat1 = 0; lat3 = 0; d1 = '0; d3 = '0;
         for (int c = 1; c <= 6; c++) begin
            if (p1_out_valid && lat1 == 0) begin lat1 = c; d1 = p1_out_data; end
            if (p3_out_valid && lat3 == 0) begin lat3 = c; d3 = p3_out_data; end
            step();
         end
         chk($sformatf("sweep%0d_lat_p1", k), 128'(lat1), 128'd1);
         chk($sformatf("sweep%0d_lat_p3", k), 128'(lat3), 128'd3);
         chk($sformatf("sweep%0d_data_p1", k), {96'b0, d1}, {96'b0, sv[k].exp});
         chk($sformatf("sweep%0d_data_p3", k), {96'b0, d3}, {96'b0, sv[k].exp});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
